// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - Instruction field positions and class constants for the decode stage
package decode_pkg;

    localparam logic [2:0] CLASS_DP_REG = 3'b000;
    localparam logic [2:0] CLASS_DP_IMM = 3'b001;
    localparam logic [2:0] CLASS_LDST   = 3'b010;
    localparam logic [2:0] CLASS_BR     = 3'b101;

    localparam int RN_LSB    = 16;
    localparam int RM_LSB    = 0;
    localparam int RD_LSB    = 12;
    localparam int RS_LSB    = 8;
    localparam int CLASS_LSB = 25;
    localparam int CLASS_W   = 3;
    localparam int LOAD_BIT  = 20;

    function automatic logic is_ldst(input logic [CLASS_W-1:0] cls);
        return cls == CLASS_LDST;
    endfunction

endpackage

// File: rtl/regfile_3r1w.sv
// rtl/regfile_3r1w.sv - 3-read/1-write register file with PC read mux; WB_BYPASS_EN forwards same-cycle writes
module regfile_3r1w #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 16,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic [ADDR_W-1:0] raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdata [3];
    logic              write_ok;

    // The PC slot has no storage and out-of-range addresses are dropped
    assign write_ok = wen && (waddr != ADDR_W'(PC_REG)) && (32'(waddr) < NUM_REGS);

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign raddr[2] = raddr_c;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];
    assign rdata_c  = rdata[2];

    // Combinational reads: PC slot returns pc+offset, else storage (or bypassed write data)
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = '0;
            if (raddr[p] == ADDR_W'(PC_REG)) begin
                rdata[p] = pc_i + DATA_W'(PC_OFFSET);
`ifdef WB_BYPASS_EN
            end else if (write_ok && (raddr[p] == waddr)) begin
                rdata[p] = wdata;
`endif
            end else if (32'(raddr[p]) < NUM_REGS) begin
                rdata[p] = regs[raddr[p]];
            end
        end
    end

    // Storage: cleared on reset, single synchronous write port
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/decode_stage_r.sv
// rtl/decode_stage_r.sv - ID-stage register with stall/flush/load-use bubble; optional WB_BYPASS_EN write-back bypass
module decode_stage_r
    import decode_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 16,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rn_o,
    output logic [DATA_W-1:0] rm_o,
    output logic [DATA_W-1:0] rs_o,
    output logic [ADDR_W-1:0] rn_addr_o,
    output logic [ADDR_W-1:0] rm_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              hazard_o
);

    logic [ADDR_W-1:0] rn_addr;
    logic [ADDR_W-1:0] rm_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] rm_val;
    logic [DATA_W-1:0] rs_val;
    logic              load_en;

    assign rn_addr = inst_i[RN_LSB +: ADDR_W];
    assign rm_addr = inst_i[RM_LSB +: ADDR_W];
    assign rd_addr = inst_i[RD_LSB +: ADDR_W];
    // Loads/stores carry their data register in the Rd field
    assign rs_addr = is_ldst(inst_i[CLASS_LSB +: CLASS_W]) ? rd_addr : inst_i[RS_LSB +: ADDR_W];

    // A load sitting in execute whose destination feeds the incoming instruction
    assign hazard_o = valid_i && valid_o
                   && is_ldst(inst_o[CLASS_LSB +: CLASS_W]) && inst_o[LOAD_BIT]
                   && ((rd_addr_o == rn_addr) || (rd_addr_o == rm_addr) || (rd_addr_o == rs_addr));

    // Flush still loads (as a dead slot); stall and bubble hold the payload
    assign load_en = flush_i || (!stall_i && !hazard_o);

    regfile_3r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .PC_REG   (PC_REG),
        .PC_OFFSET(PC_OFFSET)
    ) u_regfile (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .pc_i   (pc_i),
        .raddr_a(rn_addr),
        .raddr_b(rm_addr),
        .raddr_c(rs_addr),
        .rdata_a(rn_val),
        .rdata_b(rm_val),
        .rdata_c(rs_val),
        .wen    (wb_en_i),
        .waddr  (wb_addr_i),
        .wdata  (wb_data_i)
    );

    // Pipeline register: reset > flush > stall > hazard bubble > normal load
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o   <= 1'b0;
            inst_o    <= '0;
            pc_o      <= '0;
            rn_o      <= '0;
            rm_o      <= '0;
            rs_o      <= '0;
            rn_addr_o <= '0;
            rm_addr_o <= '0;
            rd_addr_o <= '0;
        end else begin
            if (load_en) begin
                inst_o    <= inst_i;
                pc_o      <= pc_i;
                rn_o      <= rn_val;
                rm_o      <= rm_val;
                rs_o      <= rs_val;
                rn_addr_o <= rn_addr;
                rm_addr_o <= rm_addr;
                rd_addr_o <= rd_addr;
            end
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (!stall_i) begin
                valid_o <= hazard_o ? 1'b0 : valid_i;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_r.sv
// tb/tb_decode_stage_r.sv - Random and directed check of decode_stage_r against a behavioural model (honours WB_BYPASS_EN)
module tb_decode_stage_r;

    logic        clk_i = 1'b0;
    logic        reset_i, valid_i, stall_i, flush_i, wb_en_i;
    logic [31:0] pc_i, inst_i, wb_data_i;
    logic [3:0]  wb_addr_i;
    logic        valid_o, hazard_o;
    logic [31:0] inst_o, pc_o, rn_o, rm_o, rs_o;
    logic [3:0]  rn_addr_o, rm_addr_o, rd_addr_o;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_regs [16];
    logic        m_valid;
    logic [31:0] m_inst, m_pc, m_rn, m_rm, m_rs;
    logic [3:0]  m_rn_a, m_rm_a, m_rd_a;

    decode_stage_r dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .pc_i     (pc_i),
        .inst_i   (inst_i),
        .valid_i  (valid_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .wb_en_i  (wb_en_i),
        .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i),
        .valid_o  (valid_o),
        .inst_o   (inst_o),
        .pc_o     (pc_o),
        .rn_o     (rn_o),
        .rm_o     (rm_o),
        .rs_o     (rs_o),
        .rn_addr_o(rn_addr_o),
        .rm_addr_o(rm_addr_o),
        .rd_addr_o(rd_addr_o),
        .hazard_o (hazard_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd15) return pc_i + 32'd8;
`ifdef WB_BYPASS_EN
        if (wb_en_i && wb_addr_i == a) return wb_data_i;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [3:0] m_rs_addr(input logic [31:0] ins);
        return (ins[27:25] == 3'b010) ? ins[15:12] : ins[11:8];
    endfunction

    function automatic logic m_hazard();
        logic [3:0] d;
        d = m_rd_a;
        return valid_i && m_valid && (m_inst[27:25] == 3'b010) && m_inst[20]
            && (d == inst_i[19:16] || d == inst_i[3:0] || d == m_rs_addr(inst_i));
    endfunction

    task automatic model_step();
        logic hz;
        if (reset_i) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_valid = 0; m_inst = 0; m_pc = 0; m_rn = 0; m_rm = 0; m_rs = 0;
            m_rn_a = 0; m_rm_a = 0; m_rd_a = 0;
        end else begin
            hz = m_hazard();
            if (flush_i || (!stall_i && !hz)) begin
                m_inst = inst_i;
                m_pc   = pc_i;
                m_rn   = m_read(inst_i[19:16]);
                m_rm   = m_read(inst_i[3:0]);
                m_rs   = m_read(m_rs_addr(inst_i));
                m_rn_a = inst_i[19:16];
                m_rm_a = inst_i[3:0];
                m_rd_a = inst_i[15:12];
            end
            if (flush_i)       m_valid = 1'b0;
            else if (!stall_i) m_valid = hz ? 1'b0 : valid_i;
            if (wb_en_i && wb_addr_i != 4'd15) m_regs[wb_addr_i] = wb_data_i;
        end
    endtask

    // Compare DUT against model on every falling edge
    always @(negedge clk_i) begin
        if (check_en) begin
            check("valid_o", 64'(valid_o), 64'(m_valid));
            check("inst_o", 64'(inst_o), 64'(m_inst));
            check("pc_o", 64'(pc_o), 64'(m_pc));
            check("rn_o", 64'(rn_o), 64'(m_rn));
            check("rm_o", 64'(rm_o), 64'(m_rm));
            check("rs_o", 64'(rs_o), 64'(m_rs));
            check("rn_addr_o", 64'(rn_addr_o), 64'(m_rn_a));
            check("rm_addr_o", 64'(rm_addr_o), 64'(m_rm_a));
            check("rd_addr_o", 64'(rd_addr_o), 64'(m_rd_a));
            check("hazard_o", 64'(hazard_o), 64'(m_hazard()));
        end
    end

    task automatic cycle();
        @(negedge clk_i);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    initial begin
        reset_i = 1; valid_i = 0; stall_i = 0; flush_i = 0; wb_en_i = 0;
        pc_i = 0; inst_i = 0; wb_addr_i = 0; wb_data_i = 0;
        cycle();
        check_en = 1'b1;
        reset_i = 0;
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset inst_o", 64'(inst_o), 64'd0);
        check("reset pc_o", 64'(pc_o), 64'd0);

        // R3=0x11, R4=0x22, then ADD R1,R3,R4
        wb_en_i = 1; wb_addr_i = 3; wb_data_i = 32'h11; cycle();
        wb_addr_i = 4; wb_data_i = 32'h22; cycle();
        wb_en_i = 0;
        inst_i = 32'hE0831004; valid_i = 1; cycle();
        check("add valid_o", 64'(valid_o), 64'd1);
        check("add rn_o", 64'(rn_o), 64'h11);
        check("add rm_o", 64'(rm_o), 64'h22);
        check("add rd_addr_o", 64'(rd_addr_o), 64'd1);

        // PC-relative read
        inst_i = 32'hE08F1004; pc_i = 32'h100; cycle();
        check("pc read rn_o", 64'(rn_o), 64'h108);

        // Three-cycle stall with changing inputs
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            inst_i = $urandom; pc_i = $urandom; cycle();
            check("stall inst_o", 64'(inst_o), 64'hE08F1004);
            check("stall rn_o", 64'(rn_o), 64'h108);
            check("stall valid_o", 64'(valid_o), 64'd1);
        end
        flush_i = 1; inst_i = 32'hE0831004; pc_i = 32'h200; cycle();
        check("flush valid_o", 64'(valid_o), 64'd0);
        check("flush inst_o", 64'(inst_o), 64'hE0831004);
        stall_i = 0; flush_i = 0;

        // Load-use: LDR R2,[R0] then ADD R5,R2,R1
        inst_i = 32'hE5902000; cycle();
        check("ldr valid_o", 64'(valid_o), 64'd1);
        check("ldr rd_addr_o", 64'(rd_addr_o), 64'd2);
        inst_i = 32'hE0825001; #1;
        check("hazard asserted", 64'(hazard_o), 64'd1);
        cycle();
        check("bubble valid_o", 64'(valid_o), 64'd0);
        check("bubble inst_o", 64'(inst_o), 64'hE5902000);
        check("hazard cleared", 64'(hazard_o), 64'd0);
        cycle();
        check("add issue valid_o", 64'(valid_o), 64'd1);
        check("add issue inst_o", 64'(inst_o), 64'hE0825001);

        // Same-cycle write-back of R3
        inst_i = 32'hE0831004; wb_en_i = 1; wb_addr_i = 3; wb_data_i = 32'hAA; cycle();
`ifdef WB_BYPASS_EN
        check("same-cycle wb rn_o", 64'(rn_o), 64'hAA);
`else
        check("same-cycle wb rn_o", 64'(rn_o), 64'h11);
`endif
        wb_en_i = 0; cycle();
        check("after wb rn_o", 64'(rn_o), 64'hAA);
        // Write to R15 must not affect the PC read
        wb_en_i = 1; wb_addr_i = 15; wb_data_i = 32'h1234; inst_i = 32'hE08F1004; pc_i = 32'h100; cycle();
        check("r15 write rn_o", 64'(rn_o), 64'h108);
        wb_en_i = 0;
        // STR R3,[R0]: store data comes from Rd
        inst_i = 32'hE5803000; cycle();
        check("str rs_o", 64'(rs_o), 64'hAA);

        // R7=0x55 then reset clears it
        wb_en_i = 1; wb_addr_i = 7; wb_data_i = 32'h55; cycle();
        wb_en_i = 0; reset_i = 1; cycle();
        reset_i = 0;
        check("post-reset valid_o", 64'(valid_o), 64'd0);
        inst_i = 32'hE0871004; valid_i = 1; cycle();
        check("post-reset r7", 64'(rn_o), 64'd0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r[27:25] = 3'b010;
            if ($urandom_range(0, 1) == 1) r[20] = 1'b1;
            r[19:16] = 4'($urandom_range(0, 4));
            r[15:12] = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) r[19:16] = 4'd15;
            inst_i    = r;
            pc_i      = $urandom;
            valid_i   = ($urandom_range(0, 3) != 0);
            stall_i   = ($urandom_range(0, 4) == 0);
            flush_i   = ($urandom_range(0, 7) == 0);
            reset_i   = ($urandom_range(0, 199) == 0);
            wb_en_i   = ($urandom_range(0, 1) == 1);
            wb_addr_i = 4'($urandom_range(0, 15));
            wb_data_i = $urandom;
            cycle();
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage_r.md
Name: decode_stage_r

Overview:
Parametrised ID-stage pipeline register for the pipelined ARM-subset CPU, sitting between fetch and execute. It decodes source/destination register addresses, reads a 3-read/1-write register file, and registers operands, instruction, PC and valid into execute. Compared with the previous decode register it adds stall-hold, flush priority over stall, load-use hazard detection with bubble insertion, PC-relative reads, and an optional write-back bypass.

Parameters:
DATA_W, 32, operand/register width
INST_W, 32, instruction width
ADDR_W, 4, register address width
NUM_REGS, 16, register count (must be <= 2**ADDR_W)
PC_REG, 15, address that reads the PC instead of storage
PC_OFFSET, 8, value added to pc_i on a PC_REG read

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
pc_i  in  DATA_W  PC of inst_i
inst_i  in  INST_W  fetched instruction
valid_i  in  1  inst_i is valid
stall_i  in  1  downstream stall: hold all outputs
flush_i  in  1  branch taken: kill the instruction being loaded
wb_en_i  in  1  write-back enable
wb_addr_i  in  ADDR_W  write-back address
wb_data_i  in  DATA_W  write-back data
valid_o  out  1  registered valid
inst_o  out  INST_W  registered instruction
pc_o  out  DATA_W  registered PC
rn_o, rm_o, rs_o  out  DATA_W  registered operands (rs = store data / Rd source)
rn_addr_o, rm_addr_o, rd_addr_o  out  ADDR_W  registered addresses
hazard_o  out  1  combinational load-use stall request to fetch

Behaviour:
- Only clk_i is used. Reset is synchronous and active-high (reset_i). On reset, all outputs are 0 (valid_o=0, inst_o=0, pc_o=0) and every register-file entry is cleared to 0.
- Address decode from inst_i:
  - rn = [19:16], rm = [3:0], rd = [15:12].
  - class = [27:25]. For class 3'b010 (LDR/STR), the rs port reads rd; otherwise rs reads [11:8].
- Register-file read is combinational. A read of PC_REG returns pc_i + PC_OFFSET, truncated to DATA_W.
- Register-file write happens at the clock edge when wb_en_i=1. A write to wb_addr_i == PC_REG is ignored, and so is any address >= NUM_REGS.
- Operands are registered: one cycle from inst_i to rn_o/rm_o/rs_o.
- hazard_o = valid_i & valid_o & (inst_o class == 010) & inst_o[20] (load) & (rd_addr_o matches rn, rm or rs of inst_i). Fetch holds inst_i while hazard_o is high.
- Per-edge priority, highest first:
  1. reset_i.
  2. flush_i: valid_o <= 0 and the other registers load normally. Flush overrides stall.
  3. stall_i: every output register holds, including valid_o.
  4. hazard_o: valid_o <= 0 (bubble); other registers hold.
  5. Otherwise load all registers; valid_o <= valid_i.
- Register-file writes happen regardless of stall, flush or hazard.
- A stall held for N cycles keeps outputs unchanged for N cycles. Operand registers sampled before a write are not refreshed during stall; the execute-stage forwarding covers this case.
- Reset asserted mid-stall clears everything on that edge.

Optional Feature:
WB_BYPASS_EN
- Defined: if wb_en_i=1 and wb_addr_i equals a read address (not PC_REG) in the same cycle, that read returns wb_data_i, so the operand register captures the new value.
- Undefined: reads return the stored (old) value; the new value is visible from the next cycle. Execute-stage forwarding must cover the one-cycle gap.

Decomposition:
- Package decode_pkg holds:
  - class constants: CLASS_DP_REG=3'b000, CLASS_DP_IMM=3'b001, CLASS_LDST=3'b010, CLASS_BR=3'b101.
  - instruction field bit positions.
  - the load bit index (20).
- One sub-module, regfile_3r1w: parametrised storage with three combinational reads, one synchronous write, the PC_REG read mux, and bypass under WB_BYPASS_EN.

Test Plan:
- Reset, then write R3=0x11 and R4=0x22; feed ADD R1,R3,R4 (0xE0831004) with valid_i=1 -> next cycle valid_o=1, rn_o=0x11, rm_o=0x22, rd_addr_o=1.
- pc_i=0x100, instruction reads rn=R15 -> rn_o=0x108.
- stall_i=1 for 3 cycles while inst_i changes -> outputs are identical to the pre-stall values. flush_i=1 together with stall_i -> valid_o=0 next cycle.
- LDR R2,[R0] in output, then ADD R5,R2,R1 at inst_i -> hazard_o=1 and valid_o=0 next cycle. After the load leaves (inst_i is held), the ADD issues.
- Same-cycle wb_en_i=1, wb_addr_i=3, wb_data_i=0xAA with a read of R3 -> with WB_BYPASS_EN, rn_o=0xAA; without it, the old value. A write to R15 -> no change to storage.
- Write R7=0x55, then reset_i -> R7 reads 0 and valid_o=0.
